risc16_ctrl_fsm: RTL
====================

# risc16_ctrl_fsm

Multi-cycle control sequencer for the 16-bit RiSC-16 datapath. It fetches each instruction through a request/acknowledge instruction-memory port, decodes the 3-bit opcode and steps the instruction through DECODE, EXEC, MEM and WB states. It drives the program counter's 3-bit next-address select, the PC load strobe, the register-file and data-memory controls, and the halt/retire status. It sits beside the datapath and is the only source of the PC select, `pc_we` and `pc_clr`.

## Interface
- `IMM_W`, default 7: width of the signed immediate field used for the HALT test.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  leave IDLE/HALT and begin fetching from address 0.
- `instr`  in  16  instruction word from instruction memory; valid when `imem_ack`=1.
- `imem_ack`  in  1  instruction-memory acknowledge.
- `dmem_ack`  in  1  data-memory acknowledge.
- `alu_eq`  in  1  datapath equality flag (rA==rB), valid in EXEC.
- `imem_req`  out  1  instruction fetch request.
- `dmem_req`  out  1  data-memory request.
- `dmem_we`  out  1  data-memory write (SW).
- `ir_we`  out  1  latch `instr` into the instruction register.
- `reg_we`  out  1  register-file write.
- `wb_sel`  out  2  writeback source: 00 ALU, 01 memory, 10 PC+1.
- `alu_src`  out  1  ALU operand B: 0 register, 1 immediate.
- `pc_sel`  out  3  PC next-address select: 110 branch target, 111 JALR target, any other code increment (driven as 000).
- `pc_we`  out  1  PC load strobe.
- `pc_clr`  out  1  one-cycle PC clear.
- `retire`  out  1  one-cycle pulse per completed instruction.
- `halted`  out  1  FSM in HALT.

## Operation
- Opcodes are `instr[15:13]`: ADD 000, ADDI 001, NAND 010, LUI 011, SW 100, LW 101, BEQ 110, JALR 111.
- HALT is JALR with `instr[IMM_W-1:0]` != 0. It performs no writes and no PC update, and enters HALT.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: all outputs 0. On `start`=1, pulse `pc_clr` and go to FETCH.
- FETCH: hold `imem_req`=1 until `imem_ack`=1. In the ack cycle, pulse `ir_we` and go to DECODE.
- DECODE: one cycle, then EXEC.
- EXEC:
  - `alu_src`=1 for ADDI/LW/SW/LUI.
  - BEQ retires here. `pc_sel`=110 if `alu_eq`=1, else 000. Next state FETCH.
  - HALT goes to HALT.
  - LW/SW go to MEM.
  - All other opcodes go to WB.
- MEM: hold `dmem_req`=1 (and `dmem_we`=1 for SW) until `dmem_ack`=1. In the ack cycle, SW retires and goes to FETCH; LW goes to WB.
- WB: one cycle, then FETCH.
  - `reg_we`=1 unless the destination rA (`instr[12:10]`) is 0; r0 writes are suppressed.
  - `wb_sel`: 01 for LW, 10 for JALR, 00 otherwise.
  - JALR: `pc_sel`=111.
- Retire rule: `pc_we` and `retire` are asserted together in exactly one cycle per instruction, the retire cycle. `pc_sel` is 000 in that cycle except for BEQ-taken and JALR.
- HALT: `halted`=1, all other outputs 0. `start`=1 pulses `pc_clr` and goes to FETCH.
- `imem_req` and `dmem_req` are never both high.

## Timing
- All outputs are Moore (decoded from state plus IR), except the ack-cycle strobes `ir_we`/`retire`/`pc_we`, which are combinational with `*_ack`.
- Latency with zero-wait memory (ack in the same cycle as req):
  - BEQ: 3 cycles.
  - ADD/ADDI/NAND/LUI/JALR/SW: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle on an ack adds 1.
- A request stays high, with stable `dmem_we`, until acked. No request is withdrawn except by reset.
- Reset asserted at any point, including mid-handshake: state goes to IDLE immediately and all outputs drop to 0. The pending request is abandoned.
- An ack arriving outside FETCH/MEM is ignored.
- `start` is ignored outside IDLE/HALT.

## Structure
- Shared package `risc16_pkg`:
  - opcode constants;
  - state enum;
  - `pc_sel` codes (`PC_INC`=000, `PC_BEQ`=110, `PC_JALR`=111);
  - `wb_sel` codes.
- Sub-module `risc16_decode`: combinational `instr` to opcode class, is_halt, rA_is_zero, alu_src.
- The FSM lives in `risc16_ctrl_fsm`.

## Test plan
- Reset low mid-FETCH with `imem_req`=1 -> next sample all outputs 0, state IDLE. After release and `start`, `pc_clr`=1 for one cycle.
- ADDI r1,r0,5 (16'h2405), zero-wait -> `ir_we` at cycle 1. `reg_we`=1, `wb_sel`=00 at cycle 4 with `pc_we`=`retire`=1, `pc_sel`=000.
- BEQ r1,r1,+2 (16'hC482) with `alu_eq`=1 -> `pc_we`=1, `pc_sel`=110 in cycle 3, no `reg_we`. Same instruction with `alu_eq`=0 -> `pc_sel`=000.
- LW r2,r0,3 (16'hA803) with `dmem_ack` delayed 2 cycles -> `dmem_req` high 3 cycles, `dmem_we`=0. WB has `wb_sel`=01, `reg_we`=1. Total 7 cycles.
- JALR r7,r3 (16'hFD80) -> WB cycle has `reg_we`=1, `wb_sel`=10, `pc_sel`=111, `pc_we`=1. ADD r0,r1,r2 (16'h0082) -> `reg_we`=0 in WB.
- HALT (16'hE001) -> `halted`=1 after EXEC, no `pc_we`. `start` pulse -> `pc_clr`, then FETCH.

Source files
------------

// File: rtl/risc16_pkg.sv
// risc16_pkg: shared opcodes, FSM states and mux select codes for the RiSC-16 control path.
package risc16_pkg;
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;
   localparam logic [2:0] PC_INC  = 3'b000;
   localparam logic [2:0] PC_BEQ  = 3'b110;
   localparam logic [2:0] PC_JALR = 3'b111;
   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_PC   = 2'b10;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
endpackage

// File: rtl/risc16_decode.sv
// risc16_decode: combinational instruction-word classification for the control FSM.
module risc16_decode
   import risc16_pkg::*;
#(
   parameter int IMM_W = 7
) (
   input  logic [15:0] instr,
   output logic [2:0]  op,
   output logic        is_halt,
   output logic        ra_zero,
   output logic        alu_src
);
   localparam logic [15:0] IMM_MASK = 16'((1 << IMM_W) - 1);
   always_comb begin
      op      = instr[15:13];
      is_halt = (op == OP_JALR) && |(instr & IMM_MASK);
      ra_zero = instr[12:10] == 3'd0;
      alu_src = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) || (op == OP_LUI);
   end
endmodule

// File: rtl/risc16_ctrl_fsm.sv
// risc16_ctrl_fsm: multi-cycle fetch/decode/exec/mem/wb sequencer driving PC, regfile and memory controls.
module risc16_ctrl_fsm
   import risc16_pkg::*;
#(
   parameter int IMM_W = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] instr,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   input  logic        alu_eq,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        ir_we,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic        alu_src,
   output logic [2:0]  pc_sel,
   output logic        pc_we,
   output logic        pc_clr,
   output logic        retire,
   output logic        halted
);
   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic [2:0]  op;
   logic        is_halt, ra_zero, dec_alu_src;
   risc16_decode #(.IMM_W(IMM_W)) u_dec (
      .instr   (ir_q),
      .op      (op),
      .is_halt (is_halt),
      .ra_zero (ra_zero),
      .alu_src (dec_alu_src)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end
   always_comb begin
      ir_d    = (state_q == S_FETCH && imem_ack) ? instr : ir_q;
      state_d = state_q;
      case (state_q)
         S_IDLE, S_HALT: state_d = start ? S_FETCH : state_q;
         S_FETCH:        state_d = imem_ack ? S_DECODE : S_FETCH;
         S_DECODE:       state_d = S_EXEC;
         S_EXEC:         state_d = (op == OP_BEQ) ? S_FETCH :
                                   is_halt ? S_HALT :
                                   (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
         S_MEM:          state_d = !dmem_ack ? S_MEM : (op == OP_SW) ? S_FETCH : S_WB;
         S_WB:           state_d = S_FETCH;
         default:        state_d = S_IDLE;
      endcase
   end
   // Retire strobes are gated by the ack so a waiting handshake never advances the PC.
   always_comb begin
      imem_req = state_q == S_FETCH;
      ir_we    = imem_req && imem_ack;
      dmem_req = state_q == S_MEM;
      dmem_we  = dmem_req && op == OP_SW;
      alu_src  = state_q == S_EXEC && dec_alu_src;
      reg_we   = state_q == S_WB && !ra_zero;
      wb_sel   = state_q != S_WB ? WB_ALU : (op == OP_LW) ? WB_MEM : (op == OP_JALR) ? WB_PC : WB_ALU;
      pc_clr   = (state_q == S_IDLE || state_q == S_HALT) && start;
      halted   = state_q == S_HALT;
      retire   = (state_q == S_EXEC && op == OP_BEQ) || (dmem_we && dmem_ack) || state_q == S_WB;
      pc_we    = retire;
      pc_sel   = (state_q == S_EXEC && op == OP_BEQ && alu_eq) ? PC_BEQ :
                 (state_q == S_WB && op == OP_JALR) ? PC_JALR : PC_INC;
   end
endmodule
